// File: rtl/mc_control_fsm_irq.sv
// -----------------------------------------------------------------------------
// mc_control_fsm_irq
//   Multi-cycle MIPS control FSM (R-type, addi, lw, sw, beq, j, eret) with a
//   vectored, prioritised interrupt front end: NUM_IRQ level-sensitive maskable
//   lines (line 0 highest priority), one rising-edge NMI, and internal EPCs.
//   An NMI may preempt a maskable handler (nesting depth 2). A maskable request
//   never preempts a handler.
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   opcode              IR[31:26], valid from DECODE onward
//   pc                  current PC, captured as EPC in IRQ_ENTRY
//   irq, irq_mask       maskable requests (level), 1 = line masked
//   nmi                 non-maskable request, rising-edge detected
//   busy                defers maskable entry (NMI ignores it)
//   alu_op, alu_src_a, alu_src_b, pc_src, i_or_d, mem_to_reg, reg_dst,
//   ir_write, mem_write, pc_write, branch, reg_write   datapath controls
//   irq_pc              handler vector in IRQ_ENTRY, restored EPC in ERET, else 0
//   irq_ack, nmi_ack    1-cycle entry acknowledges
//   in_isr              a handler is active
//   illegal_op          1-cycle pulse in DECODE on an unknown opcode
//   state               current state encoding (debug)
// -----------------------------------------------------------------------------
module mc_control_fsm_irq #(
  parameter int unsigned     NUM_IRQ    = 4,
  parameter int unsigned     PC_W       = 32,
  parameter logic [PC_W-1:0] VEC_BASE   = 32'h40,
  parameter logic [PC_W-1:0] VEC_STRIDE = 32'h10,
  parameter logic [5:0]      OP_ERET    = 6'h10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic [PC_W-1:0]    pc,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [NUM_IRQ-1:0] irq_mask,
  input  logic               nmi,
  input  logic               busy,
  output logic [1:0]         alu_op,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         pc_src,
  output logic               i_or_d,
  output logic               mem_to_reg,
  output logic               reg_dst,
  output logic               ir_write,
  output logic               mem_write,
  output logic               pc_write,
  output logic               branch,
  output logic               reg_write,
  output logic [PC_W-1:0]    irq_pc,
  output logic [NUM_IRQ-1:0] irq_ack,
  output logic               nmi_ack,
  output logic               in_isr,
  output logic               illegal_op,
  output logic [3:0]         state
);

  localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADR   = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_ALU_WB    = 4'd7,
    S_BRANCH    = 4'd8,
    S_ADDI_EX   = 4'd9,
    S_ADDI_WB   = 4'd10,
    S_JUMP      = 4'd11,
    S_IRQ_ENTRY = 4'd12,
    S_ERET      = 4'd13
  } state_e;

  state_e            state_q, state_d;
  logic              run_q;        // 0 until the first clock after reset release
  logic              nmi_prev_q;
  logic              nmi_pend_q;
  logic              nmi_act_q;
  logic              irq_act_q;
  logic [PC_W-1:0]   epc_n_q;
  logic [PC_W-1:0]   epc_m_q;
  logic              entry_nmi_q;  // entry choice latched at the FETCH edge
  logic [IDX_W-1:0]  entry_idx_q;

  logic [NUM_IRQ-1:0] irq_req;
  logic [IDX_W-1:0]   irq_idx;
  logic               in_fetch;
  logic               take_nmi;
  logic               take_irq;
  logic               nmi_edge;
  logic [PC_W-1:0]    vector;

  assign in_isr   = irq_act_q | nmi_act_q;
  assign state    = state_q;
  assign irq_req  = irq & ~irq_mask;
  assign in_fetch = run_q && (state_q == S_FETCH);
  assign take_nmi = in_fetch & nmi_pend_q & ~nmi_act_q;
  assign take_irq = in_fetch & ~in_isr & ~busy & (|irq_req);
  // The first sampled nmi level after reset only seeds the edge detector.
  assign nmi_edge = run_q & nmi & ~nmi_prev_q;

  assign vector = entry_nmi_q ? VEC_BASE
                              : VEC_BASE + (PC_W'(entry_idx_q) + PC_W'(1)) * VEC_STRIDE;

  // Lowest pending unmasked line wins.
  always_comb begin
    irq_idx = '0;
    for (int unsigned k = NUM_IRQ; k > 0; k--) begin
      if (irq_req[k-1]) irq_idx = IDX_W'(k-1);
    end
  end

  // Moore decode of the current state; only FETCH looks at the interrupt gate.
  always_comb begin
    state_d    = state_q;
    alu_op     = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    pc_src     = 2'd0;
    i_or_d     = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    reg_write  = 1'b0;
    irq_pc     = '0;
    irq_ack    = '0;
    nmi_ack    = 1'b0;
    illegal_op = 1'b0;

    if (!run_q) begin
      state_d = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          alu_src_b = 2'd1;
          if (take_nmi || take_irq) begin
            state_d = S_IRQ_ENTRY;
          end else begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          if (opcode == 6'd0)                             state_d = S_EXECUTE;
          else if (opcode == 6'd8)                        state_d = S_ADDI_EX;
          else if (opcode == 6'd35 || opcode == 6'd43)    state_d = S_MEM_ADR;
          else if (opcode == 6'd4)                        state_d = S_BRANCH;
          else if (opcode == 6'd2)                        state_d = S_JUMP;
          else if (opcode == OP_ERET && in_isr)           state_d = S_ERET;
          else begin
            illegal_op = 1'b1;
            state_d    = S_FETCH;
          end
        end
        S_MEM_ADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          state_d   = (opcode == 6'd35) ? S_MEM_READ : S_MEM_WRITE;
        end
        S_MEM_READ: begin
          i_or_d  = 1'b1;
          state_d = S_MEM_WB;
        end
        S_MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEM_WRITE: begin
          i_or_d    = 1'b1;
          mem_write = 1'b1;
          state_d   = S_FETCH;
        end
        S_EXECUTE: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
          state_d   = S_ALU_WB;
        end
        S_ALU_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd1;
          pc_src    = 2'd1;
          branch    = 1'b1;
          state_d   = S_FETCH;
        end
        S_ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          state_d   = S_ADDI_WB;
        end
        S_ADDI_WB: begin
          reg_write = 1'b1;
          state_d   = S_FETCH;
        end
        S_JUMP: begin
          pc_src   = 2'd2;
          pc_write = 1'b1;
          state_d  = S_FETCH;
        end
        S_IRQ_ENTRY: begin
          pc_src   = 2'd3;
          pc_write = 1'b1;
          irq_pc   = vector;
          if (entry_nmi_q) nmi_ack = 1'b1;
          else             irq_ack = NUM_IRQ'(1) << entry_idx_q;
          state_d = S_FETCH;
        end
        S_ERET: begin
          pc_src   = 2'd3;
          pc_write = 1'b1;
          irq_pc   = nmi_act_q ? epc_n_q : epc_m_q;
          state_d  = S_FETCH;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      run_q       <= 1'b0;
      nmi_prev_q  <= 1'b0;
      nmi_pend_q  <= 1'b0;
      nmi_act_q   <= 1'b0;
      irq_act_q   <= 1'b0;
      epc_n_q     <= '0;
      epc_m_q     <= '0;
      entry_nmi_q <= 1'b0;
      entry_idx_q <= '0;
    end else begin
      run_q      <= 1'b1;
      nmi_prev_q <= nmi;
      state_q    <= state_d;

      // A fresh edge wins over the clear so it is not lost during entry.
      if (nmi_edge)                                     nmi_pend_q <= 1'b1;
      else if (state_q == S_IRQ_ENTRY && entry_nmi_q)   nmi_pend_q <= 1'b0;

      if (take_nmi || take_irq) begin
        entry_nmi_q <= take_nmi;
        entry_idx_q <= irq_idx;
      end

      if (state_q == S_IRQ_ENTRY) begin
        if (entry_nmi_q) begin
          epc_n_q   <= pc;
          nmi_act_q <= 1'b1;
        end else begin
          epc_m_q   <= pc;
          irq_act_q <= 1'b1;
        end
      end

      // Innermost handler (NMI) returns first.
      if (state_q == S_ERET) begin
        if (nmi_act_q) nmi_act_q <= 1'b0;
        else           irq_act_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mc_control_fsm_irq.sv
// -----------------------------------------------------------------------------
// tb_mc_control_fsm_irq
//   Self-checking bench for mc_control_fsm_irq. A reference model works at the
//   instruction level: each fetched opcode expands into its list of states,
//   and interrupt entry/return is tracked with plain flags and EPC variables.
//   Directed scenarios come first, then randomized traffic.
// -----------------------------------------------------------------------------
module tb_mc_control_fsm_irq;

  localparam logic [5:0] ERET_OP = 6'h10;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  opcode = '0;
  logic [31:0] pc = '0;
  logic [3:0]  irq = '0;
  logic [3:0]  irq_mask = '0;
  logic        nmi = 1'b0;
  logic        busy = 1'b0;
  logic [1:0]  alu_op, alu_src_b, pc_src;
  logic        alu_src_a, i_or_d, mem_to_reg, reg_dst, ir_write, mem_write;
  logic        pc_write, branch, reg_write, nmi_ack, in_isr, illegal_op;
  logic [31:0] irq_pc;
  logic [3:0]  irq_ack;
  logic [3:0]  state;
  logic [14:0] ctrl_bus;

  always #5 clk = ~clk;

  mc_control_fsm_irq #(
    .NUM_IRQ(4), .PC_W(32), .VEC_BASE(32'h40), .VEC_STRIDE(32'h10), .OP_ERET(ERET_OP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .pc(pc), .irq(irq), .irq_mask(irq_mask),
    .nmi(nmi), .busy(busy), .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .pc_src(pc_src), .i_or_d(i_or_d), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .ir_write(ir_write), .mem_write(mem_write), .pc_write(pc_write), .branch(branch),
    .reg_write(reg_write), .irq_pc(irq_pc), .irq_ack(irq_ack), .nmi_ack(nmi_ack),
    .in_isr(in_isr), .illegal_op(illegal_op), .state(state)
  );

  assign ctrl_bus = {alu_op, alu_src_a, alu_src_b, pc_src, i_or_d, mem_to_reg, reg_dst,
                     ir_write, mem_write, pc_write, branch, reg_write};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Drive values for the next cycle
  logic [5:0]  d_opc = 6'd35;
  logic [31:0] d_pc = '0;
  logic [3:0]  d_irq = '0, d_mask = '0;
  logic        d_nmi = 1'b0, d_busy = 1'b0;

  // Reference model
  bit          m_run, m_pend, m_nact, m_iact, m_prev, m_ent_nmi;
  int          m_cur, m_ent_idx;
  int          q[$];
  logic [31:0] m_epcn, m_epcm;

  // {alu_op, a, b, pc_src, i_or_d, mem_to_reg, reg_dst, ir_write, mem_write, pc_write, branch, reg_write}
  function automatic logic [14:0] cw(logic [1:0] op, logic a, logic [1:0] b, logic [1:0] ps,
                                     logic [7:0] en);
    return {op, a, b, ps, en};
  endfunction

  function automatic logic [14:0] exp_ctrl(int st, bit take);
    case (st)
      0:  return take ? cw(2'd0, 1'b0, 2'd1, 2'd0, 8'h00) : cw(2'd0, 1'b0, 2'd1, 2'd0, 8'h14);
      1:  return cw(2'd0, 1'b0, 2'd3, 2'd0, 8'h00);
      2:  return cw(2'd0, 1'b1, 2'd2, 2'd0, 8'h00);
      3:  return cw(2'd0, 1'b0, 2'd0, 2'd0, 8'h80);
      4:  return cw(2'd0, 1'b0, 2'd0, 2'd0, 8'h41);
      5:  return cw(2'd0, 1'b0, 2'd0, 2'd0, 8'h88);
      6:  return cw(2'd2, 1'b1, 2'd0, 2'd0, 8'h00);
      7:  return cw(2'd0, 1'b0, 2'd0, 2'd0, 8'h21);
      8:  return cw(2'd1, 1'b1, 2'd0, 2'd1, 8'h02);
      9:  return cw(2'd0, 1'b1, 2'd2, 2'd0, 8'h00);
      10: return cw(2'd0, 1'b0, 2'd0, 2'd0, 8'h01);
      11: return cw(2'd0, 1'b0, 2'd0, 2'd2, 8'h04);
      default: return cw(2'd0, 1'b0, 2'd0, 2'd3, 8'h04); // 12, 13
    endcase
  endfunction

  function automatic void model_reset();
    m_run = 0; m_cur = 0; m_pend = 0; m_nact = 0; m_iact = 0; m_prev = 0;
    m_ent_nmi = 0; m_ent_idx = 0; m_epcn = '0; m_epcm = '0;
    q.delete();
  endfunction

  // One clock cycle: apply inputs, check outputs at negedge, advance model.
  task automatic step();
    bit          take_n, take_i, edge_n, legal, isr;
    int          idx;
    logic [3:0]  req;
    logic [31:0] vec, exp_pc;
    logic [3:0]  exp_ack;
    opcode = d_opc; pc = d_pc; irq = d_irq; irq_mask = d_mask; nmi = d_nmi; busy = d_busy;

    isr = m_iact || m_nact;
    req = d_irq & ~d_mask;
    idx = 0;
    for (int i = 3; i >= 0; i--) if (req[i]) idx = i;
    take_n = m_run && m_cur == 0 && m_pend && !m_nact;
    take_i = m_run && m_cur == 0 && !take_n && !isr && !d_busy && (req != 0);
    vec    = m_ent_nmi ? 32'h40 : 32'h40 + (m_ent_idx + 1) * 32'h10;
    exp_pc = (m_cur == 12) ? vec : (m_cur == 13) ? (m_nact ? m_epcn : m_epcm) : 32'h0;
    exp_ack = (m_cur == 12 && !m_ent_nmi) ? 4'(1 << m_ent_idx) : 4'h0;
    legal  = (d_opc inside {6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd2}) || (d_opc == ERET_OP && isr);

    @(negedge clk);
    chk("state",   state,      m_cur);
    chk("ctrl",    ctrl_bus,   m_run ? exp_ctrl(m_cur, take_n || take_i) : 15'h0);
    chk("irq_pc",  irq_pc,     exp_pc);
    chk("irq_ack", irq_ack,    exp_ack);
    chk("nmi_ack", nmi_ack,    m_cur == 12 && m_ent_nmi);
    chk("in_isr",  in_isr,     isr);
    chk("illegal", illegal_op, m_run && m_cur == 1 && !legal);

    edge_n = m_run && d_nmi && !m_prev;
    m_prev = d_nmi;
    if (edge_n) m_pend = 1;
    else if (m_cur == 12 && m_ent_nmi) m_pend = 0;

    if (!m_run) begin
      m_run = 1;
      m_cur = 0;
    end else if (m_cur == 0) begin
      if (take_n || take_i) begin
        m_ent_nmi = take_n;
        m_ent_idx = idx;
        m_cur = 12;
      end else begin
        q.push_back(1);
        case (d_opc)
          6'd0:  begin q.push_back(6); q.push_back(7); end
          6'd8:  begin q.push_back(9); q.push_back(10); end
          6'd35: begin q.push_back(2); q.push_back(3); q.push_back(4); end
          6'd43: begin q.push_back(2); q.push_back(5); end
          6'd4:  q.push_back(8);
          6'd2:  q.push_back(11);
          default: if (d_opc == ERET_OP && isr) q.push_back(13);
        endcase
        m_cur = q.pop_front();
      end
    end else begin
      if (m_cur == 12) begin
        if (m_ent_nmi) begin m_epcn = d_pc; m_nact = 1; end
        else           begin m_epcm = d_pc; m_iact = 1; end
      end
      if (m_cur == 13) begin
        if (m_nact) m_nact = 0;
        else        m_iact = 0;
      end
      m_cur = (q.size() > 0) ? q.pop_front() : 0;
    end
    @(posedge clk); #1;
  endtask

  // Called at posedge+1; asserts reset mid-cycle, holds it across one edge.
  task automatic do_reset();
    #2;
    chk("mw_before_rst", mem_write, m_run && m_cur == 5);
    rst_n = 1'b0;
    #1;
    chk("rst_state",  state,    4'd0);
    chk("rst_ctrl",   ctrl_bus, 15'h0);
    chk("rst_in_isr", in_isr,   1'b0);
    chk("rst_pulses", {irq_ack, nmi_ack, illegal_op, irq_pc}, '0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] opc);
    int guard = 0;
    d_opc = opc;
    step();
    while (m_cur != 0 && guard < 8) begin
      step();
      guard++;
    end
  endtask

  logic [5:0] opc_tbl [9] = '{6'd0, 6'd8, 6'd35, 6'd43, 6'd4, 6'd2, ERET_OP, 6'h3F, 6'h21};

  initial begin
    model_reset();
    @(posedge clk); #1;
    do_reset();
    step();                                  // idle cycle right after release

    run_instr(6'd35);                        // lw: 0,1,2,3,4,0

    d_irq = 4'b0110; d_pc = 32'h100;
    run_instr(6'd0);                         // entry on line 1, vector 0x60
    d_irq = '0;
    run_instr(ERET_OP);                      // back to 0x100

    d_irq = 4'b0001; d_busy = 1'b1;
    run_instr(6'd0);                         // deferred by busy
    d_busy = 1'b0; d_mask = 4'b0001;
    run_instr(6'd8);                         // masked
    d_mask = '0; d_pc = 32'h100;
    run_instr(6'd0);                         // entry on line 0, vector 0x50
    d_irq = '0;

    d_pc = 32'h64; d_nmi = 1'b1;
    run_instr(6'd0);                         // edge seen, R-type still runs
    run_instr(6'd0);                         // NMI entry over maskable ISR
    d_nmi = 1'b0; d_pc = 32'h200;
    run_instr(ERET_OP);                      // -> 0x64
    run_instr(ERET_OP);                      // -> 0x100, in_isr drops

    run_instr(6'h3F);                        // illegal
    run_instr(ERET_OP);                      // eret outside ISR is illegal
    run_instr(6'd43);
    run_instr(6'd4);
    run_instr(6'd2);

    d_irq = 4'b0100;
    run_instr(6'd0);                         // maskable entry, line 2
    d_irq = '0; d_nmi = 1'b1; d_opc = 6'd43;
    for (int g = 0; g < 6 && m_cur != 5; g++) step();
    do_reset();                              // during MEM_WRITE with NMI pending
    step();                                  // nmi still high: not an edge
    run_instr(6'd0);
    run_instr(6'd0);
    d_nmi = 1'b0;

    for (int n = 0; n < 4000; n++) begin
      if (m_cur == 0) begin
        if ((m_iact || m_nact) && $urandom_range(0, 2) == 0) d_opc = ERET_OP;
        else d_opc = opc_tbl[$urandom_range(0, 8)];
      end
      d_irq  = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
      d_mask = ($urandom_range(0, 1) == 0) ? 4'($urandom) : 4'h0;
      d_busy = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 24) == 0) d_nmi = ~d_nmi;
      d_pc = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
